// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: synchronises din, validates start bits, samples mid-bit
// on sample_tick and delivers bytes with a valid/ack handshake. RX_MAJORITY_EN enables 2-of-3 voting.
module uart_rx_sampler #(
  parameter int DATA_BITS    = 8,
  parameter int SAMPLE_RATIO = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 din,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE_RATIO);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLE_RATIO - 1);
  localparam logic [CW-1:0] C_MID  = CW'(SAMPLE_RATIO / 2);
  localparam logic [CW-1:0] C_PRE  = CW'(SAMPLE_RATIO / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic                   sync1;
  logic                   ds;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   samp_b;
  logic                   bit_val;
  logic                   commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      ds    <= 1'b1;
    end else begin
      sync1 <= din;
      ds    <= sync1;
    end
  end

`ifdef RX_MAJORITY_EN
  localparam logic [CW-1:0] C_PRE2 = CW'(SAMPLE_RATIO / 2 - 2);
  logic samp_a;

  // Third vote is the live sample at the decision tick itself.
  always_comb begin
    bit_val = (samp_a & samp_b) | (samp_a & ds) | (samp_b & ds);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      samp_a <= 1'b0;
    else if (sample_tick && state != IDLE && cnt == C_PRE2)
      samp_a <= ds;
  end
`else
  always_comb begin
    bit_val = samp_b;
  end
`endif

  always_comb begin
    commit = (state == STOP) && sample_tick && (cnt == C_MID) && bit_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      samp_b       <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;

      // A commit coinciding with ack treats the old byte as taken: no overrun.
      if (commit) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_ack ? 1'b0 : (rx_overrun | rx_valid);
      end else if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      if (sample_tick) begin
        if (state != IDLE && cnt == C_PRE)
          samp_b <= ds;

        case (state)
          IDLE: begin
            if (!ds) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == C_MID && bit_val) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == C_LAST) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == C_MID)
              shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (cnt == C_LAST) begin
              cnt <= '0;
              if (bit_idx == B_LAST)
                state <= STOP;
              else
                bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == C_MID) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              if (!bit_val)
                rx_frame_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames driven one sample tick at a time,
// sample_tick every 4 clk, outputs checked at the falling clock edge.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       din = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int ferr_cycles = 0;

  uart_rx_sampler #(.DATA_BITS(8), .SAMPLE_RATIO(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .din          (din),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rx_frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each call is one sample period: din set at a falling edge, seen synchronised
  // by the DUT before the tick that closes the period.
  task automatic send_tick(input logic v);
    din = v;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic send_bit(input logic v, input int n);
    for (int i = 0; i < n; i++) send_tick(v);
  endtask

  // glitch_bit >= 0 flips one tick of that data bit: the first low tick is the
  // detection tick, so DUT cnt = M-1 falls on tick index 8 of each bench bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
    send_bit(1'b0, 16);
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 16; j++)
        send_tick((b == glitch_bit && j == 8) ? ~d[b] : d[b]);
    end
    send_bit(stop_v, 16);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_frame_err", rx_frame_err, 1'b0);
    chk("reset rx_overrun", rx_overrun, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b1, 4);

    // Good frame 0x55
    send_frame(8'h55, 1'b1, -1);
    chk("0x55 rx_data", rx_data, 8'h55);
    chk("0x55 rx_valid", rx_valid, 1'b1);
    chk("0x55 no frame_err", ferr_cycles, 0);
    chk("0x55 busy idle", busy, 1'b0);
    send_bit(1'b1, 3);
    chk("0x55 valid held", rx_valid, 1'b1);
    do_ack();
    chk("0x55 ack clears valid", rx_valid, 1'b0);

    // False start: 3 low ticks then high
    send_bit(1'b0, 3);
    chk("false start busy high", busy, 1'b1);
    send_bit(1'b1, 12);
    chk("false start busy low", busy, 1'b0);
    chk("false start no valid", rx_valid, 1'b0);

    // Frame 0xA3 with low stop bit
    send_frame(8'hA3, 1'b0, -1);
    send_bit(1'b1, 20);
    chk("0xA3 frame_err one clk", ferr_cycles, 1);
    chk("0xA3 rx_data kept", rx_data, 8'h55);
    chk("0xA3 no valid", rx_valid, 1'b0);
    chk("0xA3 busy idle", busy, 1'b0);

    // Overrun: 0x12 then 0x34 without ack
    send_frame(8'h12, 1'b1, -1);
    chk("0x12 valid", rx_valid, 1'b1);
    chk("0x12 no overrun", rx_overrun, 1'b0);
    send_frame(8'h34, 1'b1, -1);
    chk("0x34 rx_data", rx_data, 8'h34);
    chk("0x34 overrun", rx_overrun, 1'b1);
    chk("0x34 valid", rx_valid, 1'b1);
    do_ack();
    chk("overrun ack valid", rx_valid, 1'b0);
    chk("overrun ack overrun", rx_overrun, 1'b0);

    // 0x00 with a single high tick at cnt=M-1 of bit 3
    send_frame(8'h00, 1'b1, 3);
`ifdef RX_MAJORITY_EN
    chk("glitch rx_data", rx_data, 8'h00);
`else
    chk("glitch rx_data", rx_data, 8'h08);
`endif
    chk("glitch valid", rx_valid, 1'b1);
    do_ack();

    // Reset during bit 4 of 0xF0
    send_bit(1'b0, 16);
    send_bit(1'b0, 64);
    send_bit(1'b1, 5);
    chk("0xF0 busy mid-frame", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-frame reset busy", busy, 1'b0);
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 4);
    chk("after reset busy", busy, 1'b0);
    chk("after reset valid", rx_valid, 1'b0);
    chk("after reset rx_data", rx_data, 8'h00);
    send_frame(8'h3C, 1'b1, -1);
    chk("0x3C rx_data", rx_data, 8'h3C);
    chk("0x3C valid", rx_valid, 1'b1);
    chk("0x3C no overrun", rx_overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
